// File: rtl/fetch_sequencer.sv
// Fetch sequencer: a two-state IDLE/RUN controller.
// In RUN it steps a five-slot one-hot phase ring and advances the PC.
// It loads the instruction register during the IR-load phase.
// In the writeback phase it either halts, redirects the PC or continues.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  input  logic [15:0] memoryData,
  input  logic        halt,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  output logic [4:0]  phase,
  output logic [15:0] IRData,
  output logic [15:0] PC,
  output logic        running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [4:0] PH_NONE  = 5'b00000;
  localparam logic [4:0] PH_FETCH = 5'b00001;
  localparam logic [4:0] PH_IR    = 5'b00010;
  localparam logic [4:0] PH_DEC   = 5'b00100;
  localparam logic [4:0] PH_MEM   = 5'b01000;
  localparam logic [4:0] PH_WB    = 5'b10000;

  state_t state;

  // Sequencer FSM; every output is a register, so no input reaches an output combinationally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= PH_NONE;
      PC      <= RESET_PC;
      IRData  <= 16'h0000;
      running <= 1'b0;
    end else if (state == IDLE) begin
      phase <= PH_NONE;
      if (exec) begin
        state   <= RUN;
        phase   <= PH_FETCH;
        running <= 1'b1;
      end
    end else begin
      case (phase)
        PH_FETCH: begin
          PC    <= PC + 16'd1;
          phase <= PH_IR;
        end
        PH_IR: begin
          IRData <= memoryData;
          phase  <= PH_DEC;
        end
        PH_DEC: phase <= PH_MEM;
        PH_MEM: phase <= PH_WB;
        PH_WB: begin
          // halt wins over a simultaneous redirect
          if (halt) begin
            state   <= IDLE;
            phase   <= PH_NONE;
            running <= 1'b0;
          end else begin
            if (branchTaken) PC <= branchTarget;
            phase <= PH_FETCH;
          end
        end
        // any non-one-hot encoding restarts the ring at fetch
        default: phase <= PH_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// stimulus, compared each cycle against an abstract step-counter model.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        exec;
  logic [15:0] memoryData;
  logic        halt;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [4:0]  phase;
  logic [15:0] IRData;
  logic [15:0] PC;
  logic        running;

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .exec         (exec),
    .memoryData   (memoryData),
    .halt         (halt),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .phase        (phase),
    .IRData       (IRData),
    .PC           (PC),
    .running      (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, step number 0..4 within the instruction
  bit          m_run;
  int          m_step;
  logic [15:0] m_pc;
  logic [15:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_phase();
    if (!m_run) return 5'b00000;
    return 5'(1 << m_step);
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_step = 0;
    m_pc   = 16'h0000;
    m_ir   = 16'h0000;
  endtask

  task automatic model_step(input bit e, input logic [15:0] md, input bit h,
                            input bit bt, input logic [15:0] tgt);
    if (!m_run) begin
      if (e) begin
        m_run  = 1;
        m_step = 0;
      end
    end else begin
      case (m_step)
        0: begin m_pc = m_pc + 16'd1; m_step = 1; end
        1: begin m_ir = md; m_step = 2; end
        2: m_step = 3;
        3: m_step = 4;
        default: begin
          if (h) m_run = 0;
          else begin
            if (bt) m_pc = tgt;
            m_step = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("phase",   32'(phase),   32'(exp_phase()));
    chk("PC",      32'(PC),      32'(m_pc));
    chk("IRData",  32'(IRData),  32'(m_ir));
    chk("running", 32'(running), 32'(m_run));
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later
  task automatic cycle(input bit e, input logic [15:0] md, input bit h,
                       input bit bt, input logic [15:0] tgt);
    @(negedge clock);
    exec = e; memoryData = md; halt = h; branchTaken = bt; branchTarget = tgt;
    @(posedge clock);
    model_step(e, md, h, bt, tgt);
    #1;
    check_all();
  endtask

  // Advance quietly until the model sits in the requested step (bounded)
  task automatic run_until(input int s);
    int k;
    k = 0;
    while (!(m_run && m_step == s) && k < 8) begin
      cycle(1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000);
      k++;
    end
    chk("reach_step", 32'(m_run && m_step == s), 32'd1);
  endtask

  logic [15:0] held_pc;

  initial begin
    reset = 1'b0; exec = 1'b0; memoryData = 16'h0000;
    halt = 1'b0; branchTaken = 1'b0; branchTarget = 16'h0000;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b1;

    // exec low keeps the block idle
    repeat (2) cycle(1'b0, 16'h2222, 1'b1, 1'b1, 16'h3333);

    // start and walk one full instruction, loading A5C3 in the IR-load phase
    cycle(1'b1, 16'h0BAD, 1'b0, 1'b0, 16'h0000);
    chk("start_phase", 32'(phase), 32'h01);
    cycle(1'b0, 16'h0BAD, 1'b0, 1'b0, 16'h0000);
    chk("pc_after_fetch", 32'(PC), 32'h0001);
    cycle(1'b1, 16'hA5C3, 1'b0, 1'b0, 16'h0000);
    chk("ir_load", 32'(IRData), 32'hA5C3);
    cycle(1'b0, 16'h5A5A, 1'b1, 1'b1, 16'h4444);
    cycle(1'b0, 16'h5A5A, 1'b0, 1'b0, 16'h0000);
    chk("ir_hold", 32'(IRData), 32'hA5C3);
    cycle(1'b0, 16'h5A5A, 1'b0, 1'b0, 16'h0000);
    chk("wrap_to_fetch", 32'(phase), 32'h01);

    // redirect at writeback
    run_until(4);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123);
    chk("branch_pc", 32'(PC), 32'h0123);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("branch_pc_inc", 32'(PC), 32'h0124);
    // redirect pulse in decode phase is ignored
    run_until(2);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0555);
    chk("branch_ignored", 32'(PC), 32'h0124);

    // PC wrap from FFFF
    run_until(4);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("pc_wrap", 32'(PC), 32'h0000);

    // halt beats branch, then resume from held PC
    run_until(4);
    held_pc = PC;
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0777);
    chk("halt_running", 32'(running), 32'd0);
    chk("halt_pc", 32'(PC), 32'(held_pc));
    repeat (2) cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0888);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("resume_phase", 32'(phase), 32'h01);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("resume_pc", 32'(PC), 32'(held_pc + 16'd1));

    // asynchronous reset in the memory phase
    run_until(3);
    @(negedge clock);
    exec = 1'b0; halt = 1'b0; branchTaken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) cycle(1'b0, 16'hCAFE, 1'b1, 1'b1, 16'hBEEF);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 3) == 0), 16'($urandom),
            bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 3) == 0),
            16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port exec  in  1  start/resume request, sampled only in IDLE.
REQ-005 SHALL have port memoryData  in  16  memory read data, valid during phase 5'b00010.
REQ-006 SHALL have port halt  in  1  halt request from decode/execute, sampled only in phase 5'b10000.
REQ-007 SHALL have port branchTaken  in  1  PC redirect request, sampled only in phase 5'b10000.
REQ-008 SHALL have port branchTarget  in  16  redirect address, sampled with branchTaken.
REQ-009 SHALL have port phase  out  5  one-hot phase: 00001 fetch, 00010 IR load, 00100 decode/read, 01000 memory, 10000 writeback; 00000 when idle.
REQ-010 SHALL have port IRData  out  16  current instruction register.
REQ-011 SHALL have port PC  out  16  program counter.
REQ-012 SHALL have port running  out  1  high in RUN state.

Function
REQ-013 SHALL implement two states, IDLE and RUN; running = (state == RUN).
REQ-014 In IDLE, phase SHALL be 5'b00000 and PC, IRData SHALL hold.
REQ-015 In IDLE with exec=1 at a rising edge, next cycle SHALL be RUN with phase=5'b00001; exec=0 keeps IDLE.
REQ-016 In RUN, phase SHALL advance one position per clock: 00001->00010->00100->01000->10000->00001; no stalls.
REQ-017 exec SHALL be ignored in RUN.
REQ-018 On the edge leaving phase 00001, PC SHALL become PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-019 On the edge leaving phase 00010, IRData SHALL capture memoryData; IRData SHALL hold in all other phases.
REQ-020 On the edge leaving phase 10000 with halt=1, state SHALL become IDLE, phase 5'b00000; PC unchanged even if branchTaken=1 (halt has priority).
REQ-021 On the edge leaving phase 10000 with halt=0 and branchTaken=1, PC SHALL load branchTarget and phase SHALL return to 00001.
REQ-022 On the edge leaving phase 10000 with halt=0 and branchTaken=0, PC SHALL hold and phase SHALL return to 00001.
REQ-023 halt, branchTaken, branchTarget SHALL have no effect outside phase 10000.
REQ-024 Resume after halt SHALL restart at phase 00001 fetching from the held PC.
REQ-025 phase SHALL be driven directly from a register (no combinational path from inputs to phase, PC, IRData, running).
REQ-026 Exactly one phase bit SHALL be set in RUN; an illegal phase encoding in RUN SHALL recover to 00001 on the next edge.

Reset
REQ-027 reset=0 SHALL immediately, independent of clock, force state=IDLE, phase=5'b00000, PC=RESET_PC, IRData=16'h0000, running=0.
REQ-028 Reset asserted mid-instruction (any phase) SHALL abandon the instruction with no pending PC/IR update after release.
REQ-029 After reset release, block SHALL stay IDLE until exec=1 is sampled.

Verification
REQ-030 Reset then exec=1 for one cycle -> phase sequence 00001,00010,00100,01000,10000,00001 on consecutive cycles; PC 0000->0001 after first phase.
REQ-031 memoryData=16'hA5C3 during phase 00010, different value other phases -> IRData=16'hA5C3 from phase 00100 until next 00010.
REQ-032 branchTaken=1, branchTarget=16'h0123 in phase 10000 -> PC=16'h0123 in next 00001, 16'h0124 after it; same pulse in phase 00100 -> no effect.
REQ-033 halt=1 and branchTaken=1 together in phase 10000 -> IDLE, phase 00000, running=0, PC unchanged; later exec=1 -> fetch resumes at held PC.
REQ-034 PC=16'hFFFF at phase 00001 -> PC=16'h0000 next cycle.
REQ-035 reset=0 asserted asynchronously during phase 01000 -> outputs at reset values before next clock edge; no update after release until exec.
